// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single data-memory port between the pipeline MEM
//            stage (core) and the debug/program-loader port (dbg). The core
//            has default priority. A saturating starvation counter forces a
//            dbg grant once dbg has been denied STARVE_LIMIT consecutive
//            cycles. dmem has a registered 1-cycle read latency and commits
//            writes at posedge, so writes finish in the issue cycle and reads
//            take an issue cycle plus a return cycle.
// Ports    :
//   clk, rst_n                 clock, synchronous active-low reset
//   core_req/we/addr/wdata     core request (held until core_stall is low)
//   core_rdata, core_stall     core load data, pipeline hold
//   dbg_req/we/addr/wdata      debug request (held until dbg_ack)
//   dbg_rdata, dbg_ack         debug read data, one-cycle completion pulse
//   mem_addr/wdata/we          dmem request port
//   mem_rdata                  dmem read data, valid the cycle after issue
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_stall,
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [XLEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        DBG_RD  = 2'd2
    } state_t;

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_wait_cnt;
    logic [3:0]      w_wait_cnt_nxt;
    logic [XLEN-1:0] r_core_rdata_q;
    logic [XLEN-1:0] r_dbg_rdata_q;
    logic            w_dbg_win;
    logic            w_core_win;

    // ------------------------------------------------------------------
    // State register and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // A read return in flight is simply dropped: no capture, no ack.
            r_state        <= IDLE;
            r_wait_cnt     <= 4'd0;
            r_core_rdata_q <= '0;
            r_dbg_rdata_q  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (r_state == CORE_RD) begin
                r_core_rdata_q <= mem_rdata;
            end
            if (r_state == DBG_RD) begin
                r_dbg_rdata_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant selection, next state and all port outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dbg_win   = 1'b0;
        w_core_win  = 1'b0;
        mem_addr    = core_addr;
        mem_wdata   = core_wdata;
        mem_we      = 1'b0;
        core_rdata  = r_core_rdata_q;
        dbg_rdata   = r_dbg_rdata_q;
        dbg_ack     = 1'b0;
        core_stall  = core_req;

        if (!rst_n) begin
            // Nothing is issued or completed while reset is held.
            core_stall  = 1'b0;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_dbg_win  = dbg_req & (~core_req | (r_wait_cnt == C_LIMIT));
                    w_core_win = core_req & ~w_dbg_win;
                    if (w_dbg_win) begin
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                        mem_we    = dbg_we;
                        if (dbg_we) begin
                            dbg_ack = 1'b1;
                        end else begin
                            w_state_nxt = DBG_RD;
                        end
                    end else if (w_core_win) begin
                        mem_we = core_we;
                        if (core_we) begin
                            core_stall = 1'b0;
                        end else begin
                            // Read issued; the core completes in the return cycle.
                            w_state_nxt = CORE_RD;
                        end
                    end
                end
                CORE_RD: begin
                    core_rdata  = mem_rdata;
                    core_stall  = 1'b0;
                    w_state_nxt = IDLE;
                end
                DBG_RD: begin
                    dbg_rdata   = mem_rdata;
                    dbg_ack     = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts every denied dbg cycle, including the
    // read-return cycles where nothing can be issued.
    // ------------------------------------------------------------------
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (w_dbg_win) begin
            w_wait_cnt_nxt = 4'd0;
        end else if (dbg_req && (r_wait_cnt != C_LIMIT)) begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a behavioural
//            dmem (registered read, write at posedge) and read-data
//            scoreboards for each requester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic        preload;
    logic [31:0] tb_mem [0:255];

    int checks   = 0;
    int failures = 0;

    logic [31:0] core_exp_q[$];
    logic [31:0] dbg_exp_q[$];

    dmem_arbiter #(
        .STARVE_LIMIT (4),
        .XLEN         (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: 1-cycle registered read, write committed at posedge.
    always @(posedge clk) begin
        if (preload) begin
            tb_mem[8'h20] <= 32'h1234_5678;
        end else begin
            if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= tb_mem[mem_addr[7:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_core_rd(input string tag);
        if (core_exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, core_rdata);
        end else begin
            chk(tag, core_rdata, core_exp_q.pop_front());
        end
    endtask

    task automatic chk_dbg_rd(input string tag);
        if (dbg_exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, dbg_rdata);
        end else begin
            chk(tag, dbg_rdata, dbg_exp_q.pop_front());
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0; preload = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'h1;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
        tick;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_core_stall", {31'd0, core_stall}, 32'd0);
        chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_core_rdata", core_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        tick;
        rst_n = 1'b1; preload = 1'b0; core_req = 1'b0;
        settle;
        chk("idle_core_stall", {31'd0, core_stall}, 32'd0);
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        tick;

        // ---------------- core write then core read ----------------
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        settle;
        chk("t1_wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t1_wr_mem_addr", mem_addr, 32'h10);
        chk("t1_wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t1_wr_stall", {31'd0, core_stall}, 32'd0);
        tick;
        core_we = 1'b0;
        core_exp_q.push_back(32'hDEAD_BEEF);
        settle;
        chk("t1_rd_issue_stall", {31'd0, core_stall}, 32'd1);
        chk("t1_rd_issue_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t1_rd_issue_addr", mem_addr, 32'h10);
        tick;
        settle;
        chk("t1_rd_ret_stall", {31'd0, core_stall}, 32'd0);
        chk_core_rd("t1_rd_ret_data");
        tick;
        core_req = 1'b0;
        settle;
        chk("t1_rd_held", core_rdata, 32'hDEAD_BEEF);
        tick;

        // ---------------- dbg read, core idle ----------------
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        dbg_exp_q.push_back(32'h1234_5678);
        settle;
        chk("t2_issue_ack", {31'd0, dbg_ack}, 32'd0);
        chk("t2_issue_addr", mem_addr, 32'h20);
        chk("t2_issue_mem_we", {31'd0, mem_we}, 32'd0);
        tick;
        settle;
        chk("t2_ret_ack", {31'd0, dbg_ack}, 32'd1);
        chk_dbg_rd("t2_ret_data");
        tick;
        dbg_req = 1'b0;
        settle;
        chk("t2_single_pulse", {31'd0, dbg_ack}, 32'd0);
        chk("t2_held", dbg_rdata, 32'h1234_5678);
        tick;

        // Fresh starvation count for the next scenario.
        rst_n = 1'b0;
        settle;
        chk("rst2_mem_we", {31'd0, mem_we}, 32'd0);
        tick;
        rst_n = 1'b1;

        // ---------------- starvation: core streams writes ----------------
        core_req = 1'b1; core_we = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h30; dbg_wdata = 32'h55;
        for (int k = 0; k < 5; k++) begin
            core_addr = 32'h40 + k; core_wdata = 32'h100 + k;
            settle;
            if (k < 4) begin
                chk("t3_deny_ack", {31'd0, dbg_ack}, 32'd0);
                chk("t3_deny_addr", mem_addr, 32'h40 + k);
                chk("t3_deny_stall", {31'd0, core_stall}, 32'd0);
            end else begin
                chk("t3_grant_ack", {31'd0, dbg_ack}, 32'd1);
                chk("t3_grant_addr", mem_addr, 32'h30);
                chk("t3_grant_wdata", mem_wdata, 32'h55);
                chk("t3_grant_mem_we", {31'd0, mem_we}, 32'd1);
                chk("t3_grant_stall", {31'd0, core_stall}, 32'd1);
            end
            tick;
        end
        dbg_req = 1'b0;
        settle;
        chk("t3_core_resume_stall", {31'd0, core_stall}, 32'd0);
        chk("t3_core_resume_addr", mem_addr, 32'h44);
        tick;
        core_req = 1'b0;
        tick;

        // ---------------- simultaneous reads ----------------
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        core_exp_q.push_back(32'h55);
        dbg_exp_q.push_back(32'hDEAD_BEEF);
        settle;
        chk("t4_c0_addr", mem_addr, 32'h30);
        chk("t4_c0_stall", {31'd0, core_stall}, 32'd1);
        chk("t4_c0_ack", {31'd0, dbg_ack}, 32'd0);
        tick;
        settle;
        chk("t4_c1_stall", {31'd0, core_stall}, 32'd0);
        chk("t4_c1_ack", {31'd0, dbg_ack}, 32'd0);
        chk_core_rd("t4_c1_core_data");
        tick;
        core_req = 1'b0;
        settle;
        chk("t4_c2_addr", mem_addr, 32'h10);
        chk("t4_c2_ack", {31'd0, dbg_ack}, 32'd0);
        tick;
        settle;
        chk("t4_c3_ack", {31'd0, dbg_ack}, 32'd1);
        chk_dbg_rd("t4_c3_dbg_data");
        tick;
        dbg_req = 1'b0;
        tick;

        // ---------------- reset during CORE_RD ----------------
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        settle;
        chk("t5_issue_stall", {31'd0, core_stall}, 32'd1);
        tick;
        rst_n = 1'b0;
        settle;
        chk("t5_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t5_rst_stall", {31'd0, core_stall}, 32'd0);
        chk("t5_rst_ack", {31'd0, dbg_ack}, 32'd0);
        tick;
        rst_n = 1'b1;
        core_we = 1'b1; core_addr = 32'h70; core_wdata = 32'hABC;
        settle;
        chk("t5_core_rdata_cleared", core_rdata, 32'd0);
        chk("t5_dbg_rdata_cleared", dbg_rdata, 32'd0);
        chk("t5_idle_wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t5_idle_wr_stall", {31'd0, core_stall}, 32'd0);
        tick;

        // ---------------- dbg drops request before grant ----------------
        // wait_cnt climbs to 2, then must hold while dbg is idle, so the
        // re-request needs only two more denials before winning.
        for (int k = 0; k < 8; k++) begin
            core_addr = 32'h50 + k; core_wdata = 32'h200 + k;
            dbg_we = 1'b1; dbg_addr = 32'h60;
            dbg_req   = (k < 2) || (k >= 5);
            dbg_wdata = (k < 2) ? 32'hBAD : 32'h77;
            settle;
            if (k < 7) begin
                chk("t6_no_ack", {31'd0, dbg_ack}, 32'd0);
                chk("t6_core_addr", mem_addr, 32'h50 + k);
                chk("t6_core_stall", {31'd0, core_stall}, 32'd0);
            end else begin
                chk("t6_regrant_ack", {31'd0, dbg_ack}, 32'd1);
                chk("t6_regrant_wdata", mem_wdata, 32'h77);
                chk("t6_regrant_stall", {31'd0, core_stall}, 32'd1);
            end
            tick;
        end
        dbg_req = 1'b0;
        settle;
        chk("t6_core_resume_addr", mem_addr, 32'h57);
        chk("t6_core_resume_stall", {31'd0, core_stall}, 32'd0);
        tick;
        core_req = 1'b0;
        tick;

        chk("sb_core_empty", core_exp_q.size(), 32'd0);
        chk("sb_dbg_empty", dbg_exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (core) and the debug/program-loader port (dbg).
- Sits between the MEM stage and dmem, which has registered (1-cycle) read latency and commits writes at posedge.
- Core has default priority. A starvation counter guarantees dbg progress.
- Stalls the pipeline while a core access is pending or blocked.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles dbg may be denied before it is forced to win; legal range 1..15.
- XLEN, 32: data/address width (from constants.vh).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- core_req  in  1  core access request, held until core_stall low
- core_we  in  1  1 = write, 0 = read
- core_addr  in  XLEN  word address
- core_wdata  in  XLEN  store data
- core_rdata  out  XLEN  load data
- core_stall  out  1  pipeline hold
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_we  in  1  1 = write
- dbg_addr  in  XLEN  word address
- dbg_wdata  in  XLEN  store data
- dbg_rdata  out  XLEN  read data
- dbg_ack  out  1  one-cycle completion pulse
- mem_addr  out  XLEN  to dmem
- mem_wdata  out  XLEN  to dmem
- mem_we  out  1  to dmem write enable
- mem_rdata  in  XLEN  from dmem, valid the cycle after address issue

Behaviour:
- Clocking and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values:
  - state = IDLE, wait_cnt = 0.
  - core_rdata_q = 0, dbg_rdata_q = 0.
  - mem_we = 0 during any cycle with rst_n low.
  - dbg_ack = 0. core_stall = core_req & rst_n.
- States: IDLE, CORE_RD, DBG_RD.
- IDLE, grant selection:
  - dbg wins if dbg_req & (~core_req | wait_cnt == STARVE_LIMIT).
  - Otherwise core wins if core_req.
  - Otherwise no grant: mem_we = 0, mem_addr/mem_wdata = core inputs.
- IDLE, granted write:
  - mem_addr/mem_wdata/mem_we = winner's inputs with mem_we = 1. Completes in the same cycle.
  - Core winner: core_stall = 0. Dbg winner: dbg_ack = 1.
  - State stays IDLE.
- IDLE, granted read:
  - Drive mem_addr with mem_we = 0.
  - Next state CORE_RD or DBG_RD. The requester sees no completion this cycle (core_stall = 1 for core).
- CORE_RD:
  - core_rdata = mem_rdata (combinational pass-through) and captured into core_rdata_q.
  - core_stall = 0. mem_we = 0. No new issue this cycle.
  - Next state IDLE.
- DBG_RD:
  - dbg_rdata = mem_rdata, captured into dbg_rdata_q. dbg_ack = 1.
  - mem_we = 0. No issue. Next state IDLE.
- Outside the read-return cycles, core_rdata/dbg_rdata output the held _q values.
- core_stall:
  - 1 when core_req and (not granted in IDLE, or granted read in IDLE, or state == DBG_RD).
  - 0 when core_req is low.
- Latency:
  - Uncontended write: 1 cycle.
  - Read: 2 cycles (issue + return).
  - Back-to-back reads from one requester: every 2 cycles.
- wait_cnt:
  - Increments, saturating at STARVE_LIMIT, every cycle dbg_req = 1 and dbg is not granted, including CORE_RD/DBG_RD cycles.
  - Cleared to 0 on dbg grant.
  - Holds when dbg_req = 0.
- Simultaneous requests: core wins until wait_cnt == STARVE_LIMIT. That cycle dbg wins and core stalls one extra cycle (two for a dbg read).
- Requests must be held stable while stalled/unacked. A requester dropping its request while not granted is legal and causes no access.
- Reset mid-read: the pending return is discarded, with no ack and no rdata capture. State goes to IDLE.
- No address decoding, alignment checks or sub-word lanes. Addresses pass through unmodified.

Test Plan:
- Core write addr 0x10 data 0xDEADBEEF, no dbg -> mem_we = 1 same cycle, core_stall = 0; a later core read of 0x10 -> core_stall = 1 for 1 cycle, core_rdata = 0xDEADBEEF in the return cycle.
- Dbg read of 0x20 (preloaded 0x12345678), core idle -> issue in cycle 0, dbg_ack = 1 with dbg_rdata = 0x12345678 in cycle 1, single pulse.
- core_req held high with continuous writes, dbg_req write 0x55 to 0x30 -> dbg denied 4 cycles, granted on the 5th (wait_cnt = 4), core_stall = 1 that cycle, wait_cnt returns to 0.
- Core read and dbg read simultaneous with wait_cnt = 0 -> core serviced in cycles 0–1, dbg issued cycle 2, dbg_ack cycle 3; core_stall low in cycle 1.
- rst_n low for 1 cycle during CORE_RD -> no core_rdata capture, core_rdata = 0 afterwards, state IDLE, mem_we = 0 during the reset cycle.
- dbg_req asserted then dropped before grant -> no memory access, dbg_ack never asserted, wait_cnt holds its value.
